// File: rtl/mux_stim_checker.sv
// LFSR-driven stimulus/response checker wrapped around an 8:1 mux: drives I/S, scores Y against I[S].
// Optional build macro MUXCHK_STOP_ON_FAIL_EN ends a run at the first mismatch.
module mux_stim_checker #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned CNT_W = 16,
  parameter logic [31:0] SEED  = 32'hACE1_1234
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_vec,
  output logic [2**SEL_W-1:0]   I,
  output logic [SEL_W-1:0]      S,
  input  logic                  Y,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [2**SEL_W-1:0]   first_fail_I,
  output logic [SEL_W-1:0]      first_fail_S
);

  localparam int unsigned DATA_W = 2**SEL_W;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      lfsr, lfsr_adv;
  logic [CNT_W-1:0] num_lat, vec_cnt, vec_inc;
  logic             mismatch, last;

  always_comb begin
    lfsr_adv  = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    vec_inc   = vec_cnt + CNT_W'(1);
    mismatch  = (Y != I[S]);
    last      = (vec_inc == num_lat);
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_vec != '0) ? DRIVE : DONE;
      end
      DRIVE: state_nxt = CHECK;
      CHECK: begin
        if (last)
          state_nxt = DONE;
`ifdef MUXCHK_STOP_ON_FAIL_EN
        else if (mismatch)
          state_nxt = DONE;
`endif
        else
          state_nxt = DRIVE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRIVE) || (state == CHECK);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= SEED;
      I            <= '0;
      S            <= '0;
      err          <= 1'b0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      first_fail_I <= '0;
      first_fail_S <= '0;
      vec_cnt      <= '0;
      num_lat      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            err          <= 1'b0;
            first_fail_I <= '0;
            first_fail_S <= '0;
            vec_cnt      <= '0;
            if (num_vec != '0) begin
              num_lat <= num_vec;
              I       <= lfsr[DATA_W-1:0];
              S       <= lfsr[DATA_W+SEL_W-1:DATA_W];
            end
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            err <= 1'b1;
            // err is cleared on every accepted start, so err==0 marks the run's first fail
            if (!err) begin
              first_fail_I <= I;
              first_fail_S <= S;
            end
          end else begin
            pass_cnt <= pass_cnt + CNT_W'(1);
          end
          lfsr    <= lfsr_adv;
          vec_cnt <= vec_inc;
          if (state_nxt == DRIVE) begin
            I <= lfsr_adv[DATA_W-1:0];
            S <= lfsr_adv[DATA_W+SEL_W-1:DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
